branch_hazard_controller: RTL and testbench
===========================================

// Module: branch_hazard_controller
// PURPOSE
//  Sequences the ID stage around branches that resolve in ID with operands forwarded from EX/MEM.
//  Detects branch and load-use dependencies, then issues stalls:
//    - holds PC and IF/ID;
//    - injects bubbles into ID/EX.
//  Drives the branch forward selects and flushes IF/ID on a taken branch or jump.
//  Keeps saturating stall and flush performance counters.
//  Sits between the hazard/forwarding datapath and the PC, IF/ID and ID/EX pipeline registers.
// PARAMETERS
//  REG_W   5   register-address width
//  CNT_W   16  width of each performance counter
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous active-low reset
//  is_branch        in   1      beq/bne decoded in ID
//  is_jump          in   1      j/jal decoded in ID
//  uses_rs, uses_rt in   1      ID instruction reads Rs / Rt
//  branch_taken     in   1      ID comparator result, valid only in RUN
//  IF_ID_Rs         in   REG_W  ID source register A
//  IF_ID_Rt         in   REG_W  ID source register B
//  ID_EX_Rd         in   REG_W  destination register of the instruction in EX
//  ID_EX_RegWrite   in   1      EX instruction writes a register
//  ID_EX_MemRead    in   1      EX instruction is a load
//  EX_MEM_Rd        in   REG_W  destination register of the instruction in MEM
//  EX_MEM_RegWrite  in   1      MEM instruction writes a register
//  EX_MEM_MemRead   in   1      MEM instruction is a load
//  pc_write         out  1      1 = PC advances
//  if_id_write      out  1      1 = IF/ID loads
//  id_ex_bubble     out  1      1 = ID/EX loads a NOP
//  if_id_flush      out  1      1 = IF/ID is cleared at the next edge
//  BranchForwardA   out  1      select EX/MEM result for branch operand A
//  BranchForwardB   out  1      select EX/MEM result for branch operand B
//  stall_count      out  CNT_W  stall cycles since reset, saturating
//  flush_count      out  CNT_W  flushes since reset, saturating
// BEHAVIOUR
//  Reset (rst_n low, async)
//    - state=RUN, remaining=0, both counters=0.
//    - While rst_n is low: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, forwards=0.
//  Match definitions
//    - Per operand X in {Rs,Rt}: matchE(X) = ID_EX_RegWrite & ID_EX_Rd!=0 & ID_EX_Rd==X & uses_X.
//    - matchM(X) is identical, using the EX_MEM_* signals.
//  Stall requirement (req), evaluated only in RUN; the larger of the two operands wins
//    - Branch operand, matchE & ID_EX_MemRead: 2 cycles.
//    - Branch operand, matchE & !MemRead: 1 cycle.
//    - Branch operand, matchM & EX_MEM_MemRead: 1 cycle.
//    - Non-branch operand, matchE & ID_EX_MemRead (load-use): 1 cycle.
//    - Anything else: 0 cycles.
//  FSM states: RUN, STALL
//    - RUN, req=0: pc_write=1, if_id_write=1, id_ex_bubble=0.
//    - RUN, req=0, forwards: BranchForwardA/B = is_branch & matchM(Rs/Rt) & !EX_MEM_MemRead.
//    - RUN, req=0, flush: if_id_flush = is_jump | (is_branch & branch_taken).
//    - RUN, req>0: holds PC and IF/ID, asserts bubble, no flush; loads remaining=req-1.
//      Goes to STALL if req-1>0, otherwise stays in RUN and re-evaluates next cycle.
//    - STALL: hold and bubble asserted, forwards=0, flush=0, decrement remaining.
//      Returns to RUN when remaining reaches 0; RUN then re-evaluates req.
//  Latency
//    - Stall outputs are combinational from state and inputs; no output register.
//    - A branch resolves in the first RUN cycle with req=0.
//  Simultaneous events and limits
//    - A stall has priority over a flush. branch_taken is ignored while req>0 or in STALL.
//    - is_jump with a dependency: the jump flushes, no stall (jumps read no registers).
//    - Rs==Rt: both forward bits follow the same rule.
//    - Register 0 never matches.
//  Counters
//    - stall_count +1 on every cycle with bubble asserted and rst_n high.
//    - flush_count +1 on every cycle with if_id_flush asserted.
//    - Both hold at 2^CNT_W-1.
//  Reset mid-stall: immediately returns to RUN and aborts the pending count; the hold is released at the first edge after rst_n rises.
// STRUCTURE
//  Shared package pipeline_ctrl_pkg holds:
//    - the state encoding (RUN=1'b0, STALL=1'b1);
//    - the stall-requirement constants STALL_NONE=0, STALL_ONE=1, STALL_TWO=2;
//    - REG_W.
//  Sub-module branch_dep_detect (combinational): produces matchE/matchM per operand, req[1:0] and the forward bits.
//  Top level keeps the FSM, the 2-bit remaining counter and the performance counters.
// TESTING
//  1. Load EX Rd=5, branch in ID on Rs=5:
//     -> 2 cycles with pc_write=0 and bubble=1, then BranchForwardA=0, stall_count=2.
//  2. ALU EX Rd=3, RegWrite=1, branch Rt=3:
//     -> 1 stall cycle, then next cycle BranchForwardB=1 with EX_MEM_Rd=3.
//  3. Branch Rs=7 with an ALU instruction in MEM writing 7, taken=1:
//     -> no stall, BranchForwardA=1, if_id_flush=1, flush_count=1.
//  4. Rd=0 writer in EX with a branch on R0 -> no stall, no forward. j in ID -> flush=1 even with a matching load in EX.
//  5. rst_n low during the STALL of case 1
//     -> outputs take reset values at once, counters=0; after release the FSM is in RUN and re-evaluates.
//  6. Force 2^CNT_W-1 stalls (CNT_W=4: 15) and continue stalling -> stall_count holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the ID-stage pipeline control logic: FSM encoding,
// stall-requirement codes and the per-operand stall rule.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_ONE  = 2'd1;
  localparam logic [1:0] STALL_TWO  = 2'd2;

  // A branch compares in ID, so it must wait for both ALU and load results;
  // other instructions only wait out a load-use in EX.
  function automatic logic [1:0] operand_req(input logic is_br,
                                             input logic match_e,
                                             input logic match_m,
                                             input logic ex_mem_read,
                                             input logic mem_mem_read);
    logic [1:0] r;
    r = STALL_NONE;
    if (is_br) begin
      if (match_e && ex_mem_read)       r = STALL_TWO;
      else if (match_e)                 r = STALL_ONE;
      else if (match_m && mem_mem_read) r = STALL_ONE;
    end else if (match_e && ex_mem_read) begin
      r = STALL_ONE;
    end
    return r;
  endfunction

  function automatic logic [1:0] max_req(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_controller_if.sv
// Bus between the hazard/forwarding datapath (master) and the branch hazard
// controller (slave).
interface branch_hazard_controller_if #(
  parameter int REG_W = pipeline_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
);
  logic             is_branch;
  logic             is_jump;
  logic             uses_rs;
  logic             uses_rt;
  logic             branch_taken;
  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic [REG_W-1:0] ID_EX_Rd;
  logic             ID_EX_RegWrite;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] EX_MEM_Rd;
  logic             EX_MEM_RegWrite;
  logic             EX_MEM_MemRead;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             BranchForwardA;
  logic             BranchForwardB;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output is_branch, is_jump, uses_rs, uses_rt, branch_taken,
    output IF_ID_Rs, IF_ID_Rt,
    output ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
    output EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
    input  BranchForwardA, BranchForwardB, stall_count, flush_count
  );

  modport slave (
    input  is_branch, is_jump, uses_rs, uses_rt, branch_taken,
    input  IF_ID_Rs, IF_ID_Rt,
    input  ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
    input  EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush,
    output BranchForwardA, BranchForwardB, stall_count, flush_count
  );

endinterface

// File: rtl/branch_hazard_controller_dep_detect.sv
// Combinational dependency detector: register matches against EX and MEM,
// the stall requirement of the ID instruction and the raw branch forwards.
module branch_dep_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = pipeline_ctrl_pkg::REG_W
) (
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] EX_MEM_Rd,
  input  logic             EX_MEM_RegWrite,
  input  logic             EX_MEM_MemRead,
  output logic [1:0]       req,
  output logic             fwd_a,
  output logic             fwd_b
);

  logic       match_e_rs;
  logic       match_e_rt;
  logic       match_m_rs;
  logic       match_m_rt;
  logic [1:0] req_rs;
  logic [1:0] req_rt;

  // R0 is hard-wired to zero, so a write to it never creates a dependency.
  always_comb begin
    match_e_rs = ID_EX_RegWrite  && (ID_EX_Rd  != '0) && (ID_EX_Rd  == IF_ID_Rs) && uses_rs;
    match_e_rt = ID_EX_RegWrite  && (ID_EX_Rd  != '0) && (ID_EX_Rd  == IF_ID_Rt) && uses_rt;
    match_m_rs = EX_MEM_RegWrite && (EX_MEM_Rd != '0) && (EX_MEM_Rd == IF_ID_Rs) && uses_rs;
    match_m_rt = EX_MEM_RegWrite && (EX_MEM_Rd != '0) && (EX_MEM_Rd == IF_ID_Rt) && uses_rt;

    req_rs = operand_req(is_branch, match_e_rs, match_m_rs, ID_EX_MemRead, EX_MEM_MemRead);
    req_rt = operand_req(is_branch, match_e_rt, match_m_rt, ID_EX_MemRead, EX_MEM_MemRead);

    // Jumps read no registers, so any apparent dependency is ignored.
    req = is_jump ? STALL_NONE : max_req(req_rs, req_rt);

    fwd_a = is_branch && match_m_rs && !EX_MEM_MemRead;
    fwd_b = is_branch && match_m_rt && !EX_MEM_MemRead;
  end

endmodule

// File: rtl/branch_hazard_controller.sv
// ID-stage branch hazard controller: stall FSM with remaining-cycle counter,
// branch forward selects, IF/ID flush and saturating performance counters.
module branch_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = pipeline_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  branch_hazard_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       req;
  logic             fwd_a_raw;
  logic             fwd_b_raw;

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       remaining_q;
  logic [1:0]       remaining_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] flush_count_q;
  logic [CNT_W-1:0] flush_count_d;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             fwd_a;
  logic             fwd_b;

  branch_dep_detect #(.REG_W(REG_W)) u_dep (
    .is_branch       (bus.is_branch),
    .is_jump         (bus.is_jump),
    .uses_rs         (bus.uses_rs),
    .uses_rt         (bus.uses_rt),
    .IF_ID_Rs        (bus.IF_ID_Rs),
    .IF_ID_Rt        (bus.IF_ID_Rt),
    .ID_EX_Rd        (bus.ID_EX_Rd),
    .ID_EX_RegWrite  (bus.ID_EX_RegWrite),
    .ID_EX_MemRead   (bus.ID_EX_MemRead),
    .EX_MEM_Rd       (bus.EX_MEM_Rd),
    .EX_MEM_RegWrite (bus.EX_MEM_RegWrite),
    .EX_MEM_MemRead  (bus.EX_MEM_MemRead),
    .req             (req),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );

  // Default is the held/bubbled pipeline; only RUN with no stall requirement
  // lets the pipeline advance, forward and flush.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    if_id_flush  = 1'b0;
    fwd_a        = 1'b0;
    fwd_b        = 1'b0;

    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (req == STALL_NONE) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            fwd_a        = fwd_a_raw;
            fwd_b        = fwd_b_raw;
            if_id_flush  = bus.is_jump || (bus.is_branch && bus.branch_taken);
          end else begin
            remaining_d = req - 2'd1;
            state_d     = (remaining_d != STALL_NONE) ? STALL : RUN;
          end
        end
        STALL: begin
          remaining_d = remaining_q - 2'd1;
          if (remaining_q <= 2'd1) begin
            remaining_d = STALL_NONE;
            state_d     = RUN;
          end
        end
        default: begin
          state_d     = RUN;
          remaining_d = STALL_NONE;
        end
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (rst_n && id_ex_bubble && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (if_id_flush && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      remaining_q   <= STALL_NONE;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.pc_write       = pc_write;
  assign bus.if_id_write    = if_id_write;
  assign bus.id_ex_bubble   = id_ex_bubble;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.BranchForwardA = fwd_a;
  assign bus.BranchForwardB = fwd_b;
  assign bus.stall_count    = stall_count_q;
  assign bus.flush_count    = flush_count_q;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed testbench for branch_hazard_controller; counters are 4 bits wide
// so saturation is reachable in a few cycles.
module tb_branch_hazard_controller;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  typedef struct {
    logic             isBranch;
    logic             isJump;
    logic             usesRs;
    logic             usesRt;
    logic             taken;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] exRd;
    logic             exRegWrite;
    logic             exMemRead;
    logic [REG_W-1:0] memRd;
    logic             memRegWrite;
    logic             memMemRead;
  } StimVec;

  logic clk = 1'b0;
  logic rst_n;
  int   errorCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  branch_hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  branch_hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic StimVec mkVec(input logic isBranch, input logic isJump,
                                   input logic usesRs, input logic usesRt, input logic taken,
                                   input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                   input logic [REG_W-1:0] exRd, input logic exRegWrite,
                                   input logic exMemRead, input logic [REG_W-1:0] memRd,
                                   input logic memRegWrite, input logic memMemRead);
    StimVec s;
    s.isBranch = isBranch;   s.isJump = isJump;       s.usesRs = usesRs;
    s.usesRt = usesRt;       s.taken = taken;         s.rs = rs;
    s.rt = rt;               s.exRd = exRd;           s.exRegWrite = exRegWrite;
    s.exMemRead = exMemRead; s.memRd = memRd;         s.memRegWrite = memRegWrite;
    s.memMemRead = memMemRead;
    return s;
  endfunction

  task automatic driveVec(input StimVec s);
    bus.is_branch       = s.isBranch;
    bus.is_jump         = s.isJump;
    bus.uses_rs         = s.usesRs;
    bus.uses_rt         = s.usesRt;
    bus.branch_taken    = s.taken;
    bus.IF_ID_Rs        = s.rs;
    bus.IF_ID_Rt        = s.rt;
    bus.ID_EX_Rd        = s.exRd;
    bus.ID_EX_RegWrite  = s.exRegWrite;
    bus.ID_EX_MemRead   = s.exMemRead;
    bus.EX_MEM_Rd       = s.memRd;
    bus.EX_MEM_RegWrite = s.memRegWrite;
    bus.EX_MEM_MemRead  = s.memMemRead;
  endtask

  // Inputs change just after a rising edge; outputs are sampled 2 ns later.
  task automatic applyStimulus(input StimVec s);
    @(posedge clk);
    #1;
    driveVec(s);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic pcw, input logic ifw,
                           input logic bub, input logic fl, input logic fa, input logic fb);
    checkOutput({tag, ".pc_write"},     16'(bus.pc_write),       16'(pcw));
    checkOutput({tag, ".if_id_write"},  16'(bus.if_id_write),    16'(ifw));
    checkOutput({tag, ".id_ex_bubble"}, 16'(bus.id_ex_bubble),   16'(bub));
    checkOutput({tag, ".if_id_flush"},  16'(bus.if_id_flush),    16'(fl));
    checkOutput({tag, ".fwdA"},         16'(bus.BranchForwardA), 16'(fa));
    checkOutput({tag, ".fwdB"},         16'(bus.BranchForwardB), 16'(fb));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    driveVec(mkVec(0,0,0,0,0, 0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    StimVec idle;
    StimVec loadUse;
    StimVec jumpVec;
    idle    = mkVec(0,0,0,0,0, 0,0, 0,0,0, 0,0,0);
    loadUse = mkVec(0,0,0,1,0, 0,6, 6,1,1, 0,0,0);
    jumpVec = mkVec(0,1,0,0,0, 0,0, 0,0,0, 0,0,0);

    // Reset values are forced even with a jump presented in ID.
    rst_n = 1'b0;
    driveVec(mkVec(0,1,1,0,0, 4,0, 4,1,1, 0,0,0));
    #3;
    checkCtrl("rst", 0, 0, 1, 0, 0, 0);
    checkOutput("rst.stall_count", 16'(bus.stall_count), 16'd0);
    checkOutput("rst.flush_count", 16'(bus.flush_count), 16'd0);

    // Case 1: load in EX feeding a branch, two stall cycles.
    resetDut();
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 5,1,1, 0,0,0));
    checkCtrl("t1.c0", 0, 0, 1, 0, 0, 0);
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 0,0,0, 5,1,1));
    checkCtrl("t1.c1", 0, 0, 1, 0, 0, 0);
    checkOutput("t1.c1.stall_count", 16'(bus.stall_count), 16'd1);
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 0,0,0, 0,0,0));
    checkCtrl("t1.c2", 1, 1, 0, 0, 0, 0);
    checkOutput("t1.c2.stall_count", 16'(bus.stall_count), 16'd2);

    // Case 2: ALU result in EX for branch Rt; taken ignored while stalling.
    resetDut();
    applyStimulus(mkVec(1,0,1,1,1, 1,3, 3,1,0, 0,0,0));
    checkCtrl("t2.c0", 0, 0, 1, 0, 0, 0);
    applyStimulus(mkVec(1,0,1,1,0, 1,3, 0,0,0, 3,1,0));
    checkCtrl("t2.c1", 1, 1, 0, 0, 0, 1);
    checkOutput("t2.c1.stall_count", 16'(bus.stall_count), 16'd1);
    checkOutput("t2.c1.flush_count", 16'(bus.flush_count), 16'd0);

    // Case 3: taken branch forwarded from MEM, no stall, one flush.
    resetDut();
    applyStimulus(mkVec(1,0,1,0,1, 7,0, 0,0,0, 7,1,0));
    checkCtrl("t3.c0", 1, 1, 0, 1, 1, 0);
    applyStimulus(idle);
    checkCtrl("t3.c1", 1, 1, 0, 0, 0, 0);
    checkOutput("t3.c1.flush_count", 16'(bus.flush_count), 16'd1);
    checkOutput("t3.c1.stall_count", 16'(bus.stall_count), 16'd0);

    // Case 4: R0 never matches, jumps flush without stalling, plus load-use,
    // plain ALU dependency and Rs==Rt forwarding.
    resetDut();
    applyStimulus(mkVec(1,0,1,1,0, 0,0, 0,1,1, 0,1,0));
    checkCtrl("t4.r0", 1, 1, 0, 0, 0, 0);
    applyStimulus(mkVec(0,1,1,0,0, 4,0, 4,1,1, 0,0,0));
    checkCtrl("t4.jump", 1, 1, 0, 1, 0, 0);
    applyStimulus(loadUse);
    checkCtrl("t4.loaduse", 0, 0, 1, 0, 0, 0);
    applyStimulus(mkVec(0,0,1,0,0, 2,0, 2,1,0, 0,0,0));
    checkCtrl("t4.aludep", 1, 1, 0, 0, 0, 0);
    applyStimulus(mkVec(1,0,1,1,0, 9,9, 0,0,0, 9,1,0));
    checkCtrl("t4.samereg", 1, 1, 0, 0, 1, 1);
    checkOutput("t4.stall_count", 16'(bus.stall_count), 16'd1);
    checkOutput("t4.flush_count", 16'(bus.flush_count), 16'd1);

    // Case 5: reset asserted during the STALL of case 1.
    resetDut();
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 5,1,1, 0,0,0));
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 0,0,0, 5,1,1));
    checkOutput("t5.pre.stall_count", 16'(bus.stall_count), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkCtrl("t5.inrst", 0, 0, 1, 0, 0, 0);
    checkOutput("t5.inrst.stall_count", 16'(bus.stall_count), 16'd0);
    @(negedge clk);
    driveVec(idle);
    rst_n = 1'b1;
    applyStimulus(mkVec(1,0,1,0,0, 5,0, 0,0,0, 0,0,0));
    checkCtrl("t5.post", 1, 1, 0, 0, 0, 0);
    checkOutput("t5.post.stall_count", 16'(bus.stall_count), 16'd0);

    // Case 6: stall counter saturates at 15.
    resetDut();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(loadUse);
      if (i == 14) checkOutput("t6.stall14", 16'(bus.stall_count), 16'd14);
      if (i == 15) checkOutput("t6.stall15", 16'(bus.stall_count), 16'd15);
    end
    checkOutput("t6.stall_hold", 16'(bus.stall_count), 16'd15);
    checkCtrl("t6.still_stalling", 0, 0, 1, 0, 0, 0);

    // Flush counter saturates the same way under back-to-back jumps.
    resetDut();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(jumpVec);
      if (i == 15) checkOutput("t6.flush15", 16'(bus.flush_count), 16'd15);
    end
    checkOutput("t6.flush_hold", 16'(bus.flush_count), 16'd15);
    checkOutput("t6.flush_nostall", 16'(bus.stall_count), 16'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
